fetch_pc_gen: RTL
=================

Name: fetch_pc_gen

Overview:
Two-wide fetch PC generator. It issues the fetch group addresses and the per-slot NPCs that index the branch predictor. It consumes the predictor's ptaken/paddress response to pick the next fetch PC, and takes redirects from the ROB on mispredict. It sits at the front of the IF stage, driving branch_predictor.IF_NPC and the I-cache fetch address.

Parameters:
RESET_PC, 64'h0, first fetch address after reset (must be 4-byte aligned)
CNT_W, 32, width of retired-fetch instruction counter

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-low; 0 = reset asserted
if_stall  in  1  downstream IF/ID cannot accept this group; hold
rob_mispredict  in  1  ROB detected mispredict; redirect fetch
rob_target  in  64  correct PC on mispredict
bp_ptaken  in  2  predictor taken per slot ([0]=slot1, [1]=slot2)
bp_paddress  in  128  predicted target per slot (slot1 = [63:0], slot2 = [127:64])
if_pc  out  128  fetch PC per slot (slot1 = [63:0])
if_npc  out  128  PC+4 per slot; drives predictor lookup
if_valid  out  2  slot valid bits
fetch_count  out  CNT_W  instructions accepted by IF/ID since reset

Behaviour:
- State: pc register (64b), FSM {BOOT, RUN, FLUSH}, fetch_count register.
- Reset (reset==0, asynchronous): pc=RESET_PC, state=BOOT, fetch_count=0.
  - Outputs at reset: if_valid=2'b00, if_pc={RESET_PC+4, RESET_PC}, if_npc={RESET_PC+8, RESET_PC+4}.
  - Reset mid-operation takes effect immediately, not at the next edge.
- Outputs (combinational from pc/state/bp_ptaken):
  - if_pc slot1=pc, slot2=pc+4.
  - if_npc slot1=pc+4, slot2=pc+8.
  - if_valid: BOOT/FLUSH -> 00; RUN -> {~bp_ptaken[0], 1}.
  - All adds are mod 2^64; wrap-around is silent.
- Predictor response is same-cycle combinational on if_npc. The block adds no latency; a taken prediction redirects the very next cycle.
- Next-PC priority on posedge, highest first:
  1. rob_mispredict=1: pc<=rob_target with [1:0] forced 0; state<=FLUSH. Applies in any state and overrides if_stall. Repeated mispredict in FLUSH reloads the target and stays in FLUSH.
  2. state BOOT: state<=RUN; pc unchanged.
  3. state FLUSH: state<=RUN; pc unchanged.
  4. RUN with if_stall=1: pc, state and fetch_count hold; outputs remain stable.
  5. RUN with if_stall=0 (group accepted):
     - bp_ptaken[0]=1 -> pc<=slot1 paddress with [1:0]=0.
     - else bp_ptaken[1]=1 -> pc<=slot2 paddress with [1:0]=0.
     - else pc<=pc+8.
     - Slot1 taken wins when both slots are taken.
- fetch_count: on an accepted group (RUN, !if_stall, !rob_mispredict), add popcount(if_valid). Wraps mod 2^CNT_W.
- A group squashed by a same-cycle mispredict is not counted.
- No X propagation: treat bp_* as don't-care outside RUN.

Test Plan:
1. RESET_PC=0; release reset, bp_ptaken=00, no stall.
   - Cycle 0: if_valid=00 (BOOT).
   - Cycle 1: if_pc={4,0}, if_npc={8,4}, if_valid=11.
   - Cycle 2: if_pc={12,8}.
   - fetch_count=2 after cycle 1.
2. At pc=8, drive bp_ptaken=01, slot1 paddress=100.
   - if_valid=01; next cycle if_pc={104,100}; fetch_count +1.
3. At pc=100, drive bp_ptaken=10, slot2=200 -> if_valid=11, next pc=200.
   - Then bp_ptaken=11, slot1=300, slot2=400 -> next pc=300.
4. At pc=16, assert if_stall for 3 cycles.
   - if_pc holds {20,16} and fetch_count is unchanged.
   - Release stall -> next pc=24.
5. While stalled at pc=24, pulse rob_mispredict with rob_target=0x43.
   - Next cycle: FLUSH, if_valid=00, pc=0x40.
   - Following cycle: RUN, if_pc={0x44,0x40}, valid=11.
   - Back-to-back mispredict (0x80 then 0xC0): pc=0xC0 after one FLUSH cycle.
6. Drop reset between clock edges while in RUN at pc=0x200 with fetch_count=10.
   - Immediately: if_valid=00, if_pc slot1=0, fetch_count=0.
   - Start at pc=0xFFFF_FFFF_FFFF_FFF8 with no prediction -> next pc=0 (wrap).

Source files
------------

// File: rtl/fetch_pc_gen.sv
// Two-wide fetch PC generator. Produces the fetch group PCs and NPCs for the I-cache and
// branch predictor. The next PC comes from a ROB redirect, a predicted-taken target or PC+8.
module fetch_pc_gen #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_stall,
    input  logic             rob_mispredict,
    input  logic [63:0]      rob_target,
    input  logic [1:0]       bp_ptaken,
    input  logic [127:0]     bp_paddress,
    output logic [127:0]     if_pc,
    output logic [127:0]     if_npc,
    output logic [1:0]       if_valid,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {StBoot, StRun, StFlush} state_e;

    state_e           state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       grp_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        if_pc    = {pc_q + 64'd4, pc_q};
        if_npc   = {pc_q + 64'd8, pc_q + 64'd4};
        if_valid = 2'b00;
        if (state_q == StRun) begin
            // Slot 2 is dropped when slot 1 is predicted taken.
            if_valid = {~bp_ptaken[0], 1'b1};
        end
        grp_cnt = {1'b0, if_valid[0]} + {1'b0, if_valid[1]};
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (rob_mispredict) begin
            pc_d    = {rob_target[63:2], 2'b00};
            state_d = StFlush;
        end else begin
            case (state_q)
                StBoot, StFlush: begin
                    state_d = StRun;
                end
                StRun: begin
                    if (!if_stall) begin
                        cnt_d = cnt_q + CNT_W'(grp_cnt);
                        if (bp_ptaken[0]) begin
                            pc_d = {bp_paddress[63:2], 2'b00};
                        end else if (bp_ptaken[1]) begin
                            pc_d = {bp_paddress[127:66], 2'b00};
                        end else begin
                            pc_d = pc_q + 64'd8;
                        end
                    end
                end
                default: begin
                    state_d = StBoot;
                end
            endcase
        end
    end

    assign fetch_count = cnt_q;

endmodule
